// File: rtl/pool_window_gather.sv
// Streaming 2x2 window gatherer: buffers one image row and emits each non-overlapping
// 2x2 window as {top-left, top-right, bottom-left, bottom-right} with valid/ready on both sides.
module pool_window_gather #(
    parameter int width_p = 8,
    parameter int cols_p  = 28,
    parameter int rows_p  = 28
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    v_i,
    input  logic [width_p-1:0]      data_i,
    output logic                    ready_o,
    output logic                    v_o,
    output logic [3:0][width_p-1:0] data_o,
    output logic                    last_o,
    input  logic                    ready_i
);
    localparam int COL_W = (cols_p > 1) ? $clog2(cols_p) : 1;
    localparam int ROW_W = (rows_p > 1) ? $clog2(rows_p) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(cols_p - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(rows_p - 1);

    logic [COL_W-1:0]          col_q, col_d;
    logic [ROW_W-1:0]          row_q, row_d;
    logic [width_p-1:0]        prev_q, prev_d;
    logic                      v_o_q, v_o_d;
    logic                      last_q, last_d;
    logic [3:0][width_p-1:0]   data_q, data_d;
    logic [width_p-1:0]        linebuf_q [cols_p];

    logic in_xfer;
    logic lb_we;
    logic win_load;

    // Accepting even when the window register will not be freed is impossible, so
    // ready_o depends only on registered state and the downstream ready.
    assign ready_o = ~v_o_q | ready_i;
    assign v_o     = v_o_q;
    assign data_o  = data_q;
    assign last_o  = last_q;

    always_comb begin
        in_xfer  = v_i & ready_o;
        lb_we    = in_xfer & ~row_q[0];
        win_load = in_xfer & row_q[0] & col_q[0];

        col_d  = col_q;
        row_d  = row_q;
        prev_d = prev_q;
        if (in_xfer) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
            if (row_q[0] && !col_q[0]) begin
                prev_d = data_i;
            end
        end

        v_o_d  = v_o_q;
        last_d = last_q;
        data_d = data_q;
        if (v_o_q && ready_i) begin
            v_o_d = 1'b0;
        end
        // A new window may replace one that is leaving in the same cycle.
        if (win_load) begin
            v_o_d     = 1'b1;
            data_d[3] = linebuf_q[col_q - COL_W'(1)];
            data_d[2] = linebuf_q[col_q];
            data_d[1] = prev_q;
            data_d[0] = data_i;
            last_d    = (row_q == ROW_LAST) && (col_q == COL_LAST);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            col_q  <= '0;
            row_q  <= '0;
            prev_q <= '0;
            v_o_q  <= 1'b0;
            last_q <= 1'b0;
            data_q <= '0;
        end else begin
            col_q  <= col_d;
            row_q  <= row_d;
            prev_q <= prev_d;
            v_o_q  <= v_o_d;
            last_q <= last_d;
            data_q <= data_d;
        end
    end

    // Line buffer holds pixel data only, so it is left out of reset.
    always_ff @(posedge clk_i) begin
        if (lb_we) begin
            linebuf_q[col_q] <= data_i;
        end
    end
endmodule

// File: tb/tb_pool_window_gather.sv
// Bench for pool_window_gather: a 4x2 instance for directed cases and a 28x28 instance
// for streaming and random traffic, both checked against a full-frame reference scoreboard.
module tb_pool_window_gather;
    localparam int W  = 8;
    localparam int SC = 4;
    localparam int SR = 2;
    localparam int LC = 28;
    localparam int LR = 28;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_i;

    logic                s_v_i, s_ready_o, s_v_o, s_last_o, s_ready_i;
    logic [W-1:0]        s_data_i;
    logic [3:0][W-1:0]   s_data_o;
    logic                l_v_i, l_ready_o, l_v_o, l_last_o, l_ready_i;
    logic [W-1:0]        l_data_i;
    logic [3:0][W-1:0]   l_data_o;

    pool_window_gather #(.width_p(W), .cols_p(SC), .rows_p(SR)) u_small (
        .clk_i(clk), .reset_i(reset_i), .v_i(s_v_i), .data_i(s_data_i), .ready_o(s_ready_o),
        .v_o(s_v_o), .data_o(s_data_o), .last_o(s_last_o), .ready_i(s_ready_i));

    pool_window_gather #(.width_p(W), .cols_p(LC), .rows_p(LR)) u_large (
        .clk_i(clk), .reset_i(reset_i), .v_i(l_v_i), .data_i(l_data_i), .ready_o(l_ready_o),
        .v_o(l_v_o), .data_o(l_data_o), .last_o(l_last_o), .ready_i(l_ready_i));

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboards: {last, tl, tr, bl, br} computed from the whole frame as it arrives.
    logic [32:0] s_q[$];
    logic [32:0] l_q[$];
    logic [W-1:0] s_img [SC*SR];
    logic [W-1:0] l_img [LC*LR];
    int s_idx = 0, l_idx = 0;
    int s_nwin = 0, l_nwin = 0, l_nlast = 0, l_acc = 0;
    logic s_hold = 1'b0, l_hold = 1'b0;
    logic [32:0] s_hold_v, l_hold_v, s_e, l_e;

    always @(negedge clk) begin
        if (reset_i) begin
            s_q.delete();
            s_idx  = 0;
            s_hold = 1'b0;
        end else begin
            if (s_hold) begin
                check("s_hold_v", s_v_o, 1'b1);
                check("s_hold_win", {s_last_o, s_data_o}, s_hold_v);
            end
            s_hold   = s_v_o && !s_ready_i;
            s_hold_v = {s_last_o, s_data_o};
            if (s_v_o && s_ready_i) begin
                check("s_q_nonempty", s_q.size() != 0, 1'b1);
                if (s_q.size() != 0) begin
                    s_e = s_q.pop_front();
                    check("s_window", {s_last_o, s_data_o}, s_e);
                    s_nwin++;
                end
            end
            if (s_v_i && s_ready_o) begin
                s_img[s_idx] = s_data_i;
                if (((s_idx / SC) % 2 == 1) && ((s_idx % SC) % 2 == 1))
                    s_q.push_back({s_idx == SC*SR-1, s_img[s_idx-SC-1], s_img[s_idx-SC],
                                   s_img[s_idx-1], s_data_i});
                s_idx = (s_idx + 1) % (SC*SR);
            end
        end
    end

    always @(negedge clk) begin
        if (reset_i) begin
            l_q.delete();
            l_idx  = 0;
            l_hold = 1'b0;
        end else begin
            if (l_hold) begin
                check("l_hold_v", l_v_o, 1'b1);
                check("l_hold_win", {l_last_o, l_data_o}, l_hold_v);
            end
            l_hold   = l_v_o && !l_ready_i;
            l_hold_v = {l_last_o, l_data_o};
            if (l_v_o && l_ready_i) begin
                check("l_q_nonempty", l_q.size() != 0, 1'b1);
                if (l_q.size() != 0) begin
                    l_e = l_q.pop_front();
                    check("l_window", {l_last_o, l_data_o}, l_e);
                    l_nwin++;
                    if (l_last_o) l_nlast++;
                end
            end
            if (l_v_i && l_ready_o) begin
                l_acc++;
                l_img[l_idx] = l_data_i;
                if (((l_idx / LC) % 2 == 1) && ((l_idx % LC) % 2 == 1))
                    l_q.push_back({l_idx == LC*LR-1, l_img[l_idx-LC-1], l_img[l_idx-LC],
                                   l_img[l_idx-1], l_data_i});
                l_idx = (l_idx + 1) % (LC*LR);
            end
        end
    end

    task automatic s_push(input logic [W-1:0] p);
        int t;
        t = 0;
        s_v_i    = 1'b1;
        s_data_i = p;
        @(negedge clk);
        while (!s_ready_o && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("s_push_ready", s_ready_o, 1'b1);
        @(posedge clk);
        #1;
        s_v_i = 1'b0;
    endtask

    task automatic s_drain();
        @(posedge clk);
        #1;
        check("s_drained", s_v_o, 1'b0);
    endtask

    logic [W-1:0] ext_pix [8];
    int bubbles;
    int cyc;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_i = 1'b1;
        s_v_i = 1'b0; s_data_i = '0; s_ready_i = 1'b1;
        l_v_i = 1'b0; l_data_i = '0; l_ready_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset_i = 1'b0;
        @(negedge clk);
        check("rst_s_v_o", s_v_o, 1'b0);
        check("rst_s_ready_o", s_ready_o, 1'b1);
        check("rst_s_last_o", s_last_o, 1'b0);
        check("rst_s_data_o", s_data_o, 32'h0);
        check("rst_l_v_o", l_v_o, 1'b0);
        check("rst_l_ready_o", l_ready_o, 1'b1);
        @(posedge clk);
        #1;

        // Basic 4x2 frame with latency checks
        for (int p = 1; p <= 8; p++) begin
            s_push(W'(p));
            if (p == 5 || p == 7) check("t1_no_win", s_v_o, 1'b0);
            if (p == 6) begin
                check("t1_lat6_v", s_v_o, 1'b1);
                check("t1_win6", s_data_o, 32'h01020506);
                check("t1_last6", s_last_o, 1'b0);
            end
            if (p == 8) begin
                check("t1_lat8_v", s_v_o, 1'b1);
                check("t1_win8", s_data_o, 32'h03040708);
                check("t1_last8", s_last_o, 1'b1);
            end
        end
        s_drain();
        check("t1_nwin", s_nwin, 2);

        // Backpressure from pixel 6
        for (int p = 1; p <= 5; p++) s_push(W'(p));
        s_ready_i = 1'b0;
        s_push(8'd6);
        s_v_i    = 1'b1;
        s_data_i = 8'd7;
        repeat (3) begin
            @(negedge clk);
            check("t2_bp_v", s_v_o, 1'b1);
            check("t2_bp_ready", s_ready_o, 1'b0);
            check("t2_bp_win", s_data_o, 32'h01020506);
        end
        @(posedge clk);
        #1;
        s_ready_i = 1'b1;
        s_push(8'd7);
        s_push(8'd8);
        check("t2_win8", {s_last_o, s_data_o}, 33'h103040708);
        s_drain();
        check("t2_nwin", s_nwin, 4);

        // Reset mid-frame with a window pending
        for (int p = 1; p <= 8; p++) s_push(W'(p));
        s_drain();
        s_ready_i = 1'b0;
        for (int p = 9; p <= 14; p++) s_push(W'(p));
        check("t3_pending", s_v_o, 1'b1);
        reset_i = 1'b1;
        @(posedge clk);
        #1;
        reset_i = 1'b0;
        @(negedge clk);
        check("t3_rst_v", s_v_o, 1'b0);
        check("t3_rst_ready", s_ready_o, 1'b1);
        check("t3_rst_data", s_data_o, 32'h0);
        @(posedge clk);
        #1;
        s_ready_i = 1'b1;
        s_nwin = 0;
        for (int p = 1; p <= 8; p++) begin
            s_push(W'(p));
            if (p == 6) check("t3_win6", s_data_o, 32'h01020506);
            if (p == 8) check("t3_win8", s_data_o, 32'h03040708);
        end
        s_drain();
        check("t3_nwin", s_nwin, 2);

        // Extreme pixel values pass through untouched
        ext_pix = '{8'hFF, 8'h00, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'hFF, 8'h00};
        for (int p = 0; p < 8; p++) begin
            s_push(ext_pix[p]);
            if (p == 5) check("t4_win_ext0", s_data_o, 32'hFF0000FF);
            if (p == 7) check("t4_win_ext1", s_data_o, 32'h00FFFF00);
        end
        s_drain();

        // Two back-to-back 28x28 ramp frames at full rate
        l_nwin  = 0;
        l_nlast = 0;
        bubbles = 0;
        l_v_i   = 1'b1;
        for (int i = 0; i < 2*LC*LR; i++) begin
            l_data_i = W'(i % 256);
            @(negedge clk);
            if (!l_ready_o) bubbles++;
            @(posedge clk);
            #1;
        end
        l_v_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("t5_bubbles", bubbles, 0);
        check("t5_nwin", l_nwin, 2*(LC/2)*(LR/2));
        check("t5_nlast", l_nlast, 2);
        check("t5_q_empty", l_q.size(), 0);

        // Random valid/ready over three frames of random data
        l_nwin = 0;
        l_acc  = 0;
        cyc    = 0;
        while (l_acc < 3*LC*LR && cyc < 40000) begin
            l_v_i     = 1'($urandom_range(0, 1));
            l_data_i  = W'($urandom);
            l_ready_i = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            cyc++;
        end
        check("t6_all_accepted", l_acc, 3*LC*LR);
        l_v_i     = 1'b0;
        l_ready_i = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("t6_nwin", l_nwin, 3*(LC/2)*(LR/2));
        check("t6_q_empty", l_q.size(), 0);
        check("t6_idle_v", l_v_o, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
